// File: rtl/clk_phase_monitor.sv
// Monitors two asynchronous phase clocks against expected period, high time and
// relative offset, locking after a run of good periods and latching the first fault.
module clk_phase_monitor #(
  parameter int unsigned EXP_PERIOD = 50,
  parameter int unsigned EXP_HIGH   = 25,
  parameter int unsigned EXP_OFFSET = 12,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_250,
  input  logic       rst,
  input  logic       clka_in,
  input  logic       clkb_in,
  input  logic       clear_fault,
  output logic [7:0] period_cnt,
  output logic [7:0] high_cnt,
  output logic [7:0] offset_cnt,
  output logic       meas_valid,
  output logic       locked,
  output logic       fault,
  output logic [2:0] fault_code
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  a_sync_q, b_sync_q;
  logic        a_rise, a_fall, b_rise;
  logic [7:0]  k_q, hi_q, off_q;
  logic        fall_seen_q;
  logic [1:0]  bcnt_q;
  logic [7:0]  per_cnt_q, high_cnt_q, off_cnt_q;
  logic        mv_q;
  logic [7:0]  good_q, good_d;
  logic [2:0]  code_q, code_d;
  logic [2:0]  close_code;
  logic        timeout;

  function automatic logic in_win(input logic [7:0] v, input int unsigned exp_v);
    int unsigned vv;
    vv = {24'd0, v};
    return (vv + TOL >= exp_v) && (vv <= exp_v + TOL);
  endfunction

  // [0],[1] are the synchronizer flops, [2] is the edge-detect register
  assign a_rise  = a_sync_q[1] & ~a_sync_q[2];
  assign a_fall  = ~a_sync_q[1] & a_sync_q[2];
  assign b_rise  = b_sync_q[1] & ~b_sync_q[2];
  assign timeout = (k_q == 8'hFF);

  // k reads the number of cycles since the last clka rise detect
  always_ff @(posedge clk_250) begin
    if (rst) begin
      a_sync_q    <= '0;
      b_sync_q    <= '0;
      k_q         <= '0;
      hi_q        <= '0;
      off_q       <= '0;
      fall_seen_q <= 1'b0;
      bcnt_q      <= '0;
      per_cnt_q   <= '0;
      high_cnt_q  <= '0;
      off_cnt_q   <= '0;
      mv_q        <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[1:0], clka_in};
      b_sync_q <= {b_sync_q[1:0], clkb_in};
      mv_q     <= 1'b0;
      if (a_rise) begin
        k_q         <= 8'd1;
        hi_q        <= '0;
        off_q       <= '0;
        fall_seen_q <= 1'b0;
        bcnt_q      <= b_rise ? 2'd1 : 2'd0;
        if (state_q != IDLE) begin
          per_cnt_q  <= k_q;
          high_cnt_q <= hi_q;
          off_cnt_q  <= off_q;
          mv_q       <= 1'b1;
        end
      end else begin
        if (k_q != 8'hFF) k_q <= k_q + 8'd1;
        if (a_fall) begin
          hi_q        <= k_q;
          fall_seen_q <= 1'b1;
        end
        if (b_rise) begin
          if (bcnt_q == 2'd0) off_q <= k_q;
          if (bcnt_q != 2'd2) bcnt_q <= bcnt_q + 2'd1;
        end
      end
    end
  end

  // Offset is only judged when a clkb rise occurred; an absent rise reports as a count error
  always_comb begin
    close_code = 3'd0;
    if (!in_win(k_q, EXP_PERIOD))                         close_code = 3'd1;
    else if (!fall_seen_q || !in_win(hi_q, EXP_HIGH))     close_code = 3'd2;
    else if (bcnt_q != 2'd0 && !in_win(off_q, EXP_OFFSET)) close_code = 3'd3;
    else if (bcnt_q != 2'd1)                              close_code = 3'd4;
  end

  always_ff @(posedge clk_250) begin
    if (rst) begin
      state_q <= IDLE;
      good_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: if (a_rise) state_d = ACQ;
      ACQ, LOCKED: begin
        if (timeout) begin
          state_d = FAULT;
          code_d  = 3'd5;
        end else if (a_rise) begin
          if (close_code != 3'd0) begin
            state_d = FAULT;
            code_d  = close_code;
          end else if (state_q == ACQ) begin
            good_d = good_q + 8'd1;
            if ({24'd0, good_q} + 1 >= LOCK_COUNT) state_d = LOCKED;
          end
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d = IDLE;
          code_d  = '0;
          good_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    locked     = (state_q == LOCKED);
    fault      = (state_q == FAULT);
    fault_code = code_q;
    period_cnt = per_cnt_q;
    high_cnt   = high_cnt_q;
    offset_cnt = off_cnt_q;
    meas_valid = mv_q;
  end

endmodule

// File: tb/tb_clk_phase_monitor.sv
// Directed bench for clk_phase_monitor: waveforms are generated cycle by cycle
// on the falling edge and outputs are compared with hand-computed values.
module tb_clk_phase_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clka = 1'b0;
  logic       clkb = 1'b0;
  logic       clear_fault = 1'b0;
  logic [7:0] period_cnt, high_cnt, offset_cnt;
  logic       meas_valid, locked, fault;
  logic [2:0] fault_code;

  int checks = 0;
  int failures = 0;

  always #2 clk = ~clk;

  clk_phase_monitor #(
    .EXP_PERIOD(50),
    .EXP_HIGH  (25),
    .EXP_OFFSET(12),
    .TOL       (1),
    .LOCK_COUNT(4)
  ) dut (
    .clk_250    (clk),
    .rst        (rst),
    .clka_in    (clka),
    .clkb_in    (clkb),
    .clear_fault(clear_fault),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .offset_cnt (offset_cnt),
    .meas_valid (meas_valid),
    .locked     (locked),
    .fault      (fault),
    .fault_code (fault_code)
  );

  task automatic drive_cycle(input logic a, input logic b);
    @(negedge clk);
    clka = a;
    clkb = b;
  endtask

  // After driving index j, the outputs reflect the clka rise of index 0 once j >= 3
  task automatic gen_range(input int per, input int high, input int off, input bit bon,
                           input int from, input int to);
    for (int i = from; i <= to; i++)
      drive_cycle(i < high, bon && (i >= off) && (i < off + 20));
  endtask

  task automatic gen_period(input int per, input int high, input int off, input bit bon);
    gen_range(per, high, off, bon, 0, per - 1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({period_cnt, high_cnt, offset_cnt, meas_valid, locked, fault, fault_code} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0",
               {period_cnt, high_cnt, offset_cnt, meas_valid, locked, fault, fault_code});
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    for (int p = 0; p < 4; p++) gen_period(50, 25, 12, 1);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL nominal_not_locked_after_4 actual=%0b required=0", locked);
    end
    gen_range(50, 25, 12, 1, 0, 2);
    checks++;
    if (meas_valid !== 1'b0) begin
      failures++;
      $display("FAIL nominal_mv_before actual=%0b required=0", meas_valid);
    end
    gen_range(50, 25, 12, 1, 3, 3);
    checks++;
    if (meas_valid !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL nominal_lock_pulse actual mv=%0b locked=%0b required mv=1 locked=1",
               meas_valid, locked);
    end
    gen_range(50, 25, 12, 1, 4, 4);
    checks++;
    if (meas_valid !== 1'b0) begin
      failures++;
      $display("FAIL nominal_mv_one_cycle actual=%0b required=0", meas_valid);
    end
    gen_range(50, 25, 12, 1, 5, 49);
    checks++;
    if (period_cnt !== 8'd50 || high_cnt !== 8'd25 || offset_cnt !== 8'd12 || fault !== 1'b0) begin
      failures++;
      $display("FAIL nominal_counts actual=%0d/%0d/%0d fault=%0b required=50/25/12 fault=0",
               period_cnt, high_cnt, offset_cnt, fault);
    end
  endtask

  task automatic test_period_fault();
    gen_period(51, 25, 12, 1);
    gen_range(50, 25, 12, 1, 0, 3);
    checks++;
    if (locked !== 1'b1 || period_cnt !== 8'd51) begin
      failures++;
      $display("FAIL period_tol_edge actual locked=%0b period=%0d required locked=1 period=51",
               locked, period_cnt);
    end
    gen_range(50, 25, 12, 1, 4, 49);
    gen_period(52, 25, 12, 1);
    gen_range(50, 25, 12, 1, 0, 2);
    checks++;
    if (locked !== 1'b1 || fault !== 1'b0) begin
      failures++;
      $display("FAIL period_before_edge actual locked=%0b fault=%0b required locked=1 fault=0",
               locked, fault);
    end
    gen_range(50, 25, 12, 1, 3, 3);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1 || locked !== 1'b0 || period_cnt !== 8'd52) begin
      failures++;
      $display("FAIL period_fault actual f=%0b code=%0d lk=%0b per=%0d required f=1 code=1 lk=0 per=52",
               fault, fault_code, locked, period_cnt);
    end
    gen_range(50, 25, 12, 1, 4, 49);
    gen_range(50, 25, 12, 1, 0, 3);
    checks++;
    if (meas_valid !== 1'b1 || fault_code !== 3'd1 || fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_sticky actual mv=%0b code=%0d f=%0b required mv=1 code=1 f=1",
               meas_valid, fault_code, fault);
    end
    gen_range(50, 25, 12, 1, 4, 49);
    do_clear();
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL period_clear actual f=%0b code=%0d lk=%0b required 0/0/0",
               fault, fault_code, locked);
    end
  endtask

  task automatic test_offset_fault();
    gen_period(50, 25, 12, 1);
    gen_period(50, 25, 14, 1);
    gen_range(50, 25, 12, 1, 0, 3);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3 || high_cnt !== 8'd25 || offset_cnt !== 8'd14) begin
      failures++;
      $display("FAIL offset_fault actual f=%0b code=%0d high=%0d off=%0d required f=1 code=3 high=25 off=14",
               fault, fault_code, high_cnt, offset_cnt);
    end
    gen_range(50, 25, 12, 1, 4, 49);
    do_clear();
  endtask

  task automatic test_clkb_missing();
    gen_period(50, 25, 12, 1);
    gen_period(50, 25, 12, 0);
    gen_range(50, 25, 12, 1, 0, 3);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4) begin
      failures++;
      $display("FAIL clkb_missing actual f=%0b code=%0d required f=1 code=4", fault, fault_code);
    end
    gen_range(50, 25, 12, 1, 4, 49);
    do_clear();
  endtask

  task automatic test_timeout();
    for (int p = 0; p < 5; p++) gen_period(50, 25, 12, 1);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL timeout_prelock actual=%0b required=1", locked);
    end
    for (int j = 0; j <= 257; j++) drive_cycle(1'b1, 1'b0);
    checks++;
    if (fault !== 1'b0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early actual f=%0b lk=%0b required f=0 lk=1", fault, locked);
    end
    drive_cycle(1'b1, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd5 || locked !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fault actual f=%0b code=%0d lk=%0b required f=1 code=5 lk=0",
               fault, fault_code, locked);
    end
    do_clear();
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0) begin
      failures++;
      $display("FAIL timeout_clear actual f=%0b code=%0d required 0/0", fault, fault_code);
    end
    for (int j = 0; j < 10; j++) drive_cycle(1'b1, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_timeout actual=%0b required=0", fault);
    end
    for (int j = 0; j < 10; j++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_acq();
    gen_period(50, 25, 12, 1);
    gen_period(50, 25, 12, 1);
    gen_range(50, 25, 12, 1, 0, 29);
    checks++;
    if (period_cnt !== 8'd50) begin
      failures++;
      $display("FAIL acq_pre_reset actual=%0d required=50", period_cnt);
    end
    rst = 1'b1;
    gen_range(50, 25, 12, 1, 30, 30);
    checks++;
    if ({period_cnt, high_cnt, offset_cnt, meas_valid, locked, fault, fault_code} !== 30'd0) begin
      failures++;
      $display("FAIL acq_reset_outputs actual=%h required=0",
               {period_cnt, high_cnt, offset_cnt, meas_valid, locked, fault, fault_code});
    end
    rst = 1'b0;
    gen_range(50, 25, 12, 1, 31, 49);
    for (int p = 0; p < 4; p++) gen_period(50, 25, 12, 1);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL relock_early actual=%0b required=0", locked);
    end
    gen_period(50, 25, 12, 1);
    checks++;
    if (locked !== 1'b1 || period_cnt !== 8'd50) begin
      failures++;
      $display("FAIL relock actual lk=%0b per=%0d required lk=1 per=50", locked, period_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_period_fault();
    test_offset_fault();
    test_clkb_missing();
    test_timeout();
    test_reset_mid_acq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
